// File: rtl/bridge_bytes_reader.sv
// -----------------------------------------------------------------------------
// bridge_bytes_reader
//
// Read-side companion of the byte-wise ROM download path. A single 32-bit
// bridge read request becomes four back-to-back byte reads on an 8-bit memory
// port with fixed read latency. The four returned bytes are packed big-endian
// (byte at base+0 in [31:24]) and returned with a one-cycle valid strobe.
//
// Parameters
//   ADDR_WIDTH   : byte address width on the memory side (3..31)
//   READ_LATENCY : cycles from mem_rd to valid mem_rd_data (1..7)
//
// Ports
//   clk          : single clock for all logic
//   reset        : asynchronous, active-high reset
//   rd           : read request pulse, sampled only while idle
//   addr         : bridge byte address; [1:0] and bits >= ADDR_WIDTH ignored
//   rd_data      : assembled word, held until the next rd_valid
//   rd_valid     : one-cycle strobe marking a new rd_data
//   busy         : high from the cycle after an accepted rd until rd_valid
//   mem_addr     : byte address to memory, holds its value when mem_rd=0
//   mem_rd       : byte read strobe
//   mem_rd_data  : memory read data, valid READ_LATENCY cycles after mem_rd
// -----------------------------------------------------------------------------
module bridge_bytes_reader #(
  parameter int ADDR_WIDTH   = 25,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic [31:0]           addr,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // A tag travels alongside each outstanding byte read so the returning data
  // can be steered to its lane without relying on a counted delay.
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } tag_t;

  state_t                state;
  logic [ADDR_WIDTH-3:0] word_addr;   // word-aligned base, low two bits implied
  logic [1:0]            issue_idx;   // byte index currently on the memory port
  logic [31:0]           acc;         // lane-addressed word accumulator
  logic [31:0]           acc_next;
  tag_t                  tag_pipe [READ_LATENCY];
  tag_t                  tag_out;
  logic                  last_capture;

  // Word alignment drops addr[1:0]; the memory space ends at ADDR_WIDTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH], addr[1:0]};

  assign tag_out      = tag_pipe[READ_LATENCY-1];
  assign last_capture = tag_out.vld && (tag_out.idx == 2'd3);

  // Lanes are written independently; the word is never shifted, so a byte
  // lands in the same place regardless of the read latency.
  // NOTE: acc_next gets a full default before the conditional writes so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (tag_out.vld) begin
      unique case (tag_out.idx)
        2'd0:    acc_next[31:24] = mem_rd_data;
        2'd1:    acc_next[23:16] = mem_rd_data;
        2'd2:    acc_next[15:8]  = mem_rd_data;
        default: acc_next[7:0]   = mem_rd_data;
      endcase
    end
  end

  // Latency tag pipeline: stage 0 records what was on the memory port this
  // cycle, the last stage lines up with the corresponding mem_rd_data.
  // NOTE: this small array is control state (valid bits), so it is reset;
  // otherwise stale tags could capture late data after a mid-read reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_t'{vld: mem_rd, idx: issue_idx};
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Control FSM with registered outputs.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      word_addr <= '0;
      issue_idx <= '0;
      acc       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      acc      <= acc_next;

      unique case (state)
        IDLE: begin
          if (rd) begin
            word_addr <= addr[ADDR_WIDTH-1:2];
            issue_idx <= 2'd0;
            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_rd    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end

        // One byte per cycle; only the low two address bits advance, so the
        // read never carries out of its word.
        ISSUE: begin
          if (issue_idx == 2'd3) begin
            mem_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            issue_idx <= issue_idx + 2'd1;
            mem_addr  <= {word_addr, issue_idx + 2'd1};
          end
        end

        // The final byte is folded in through acc_next so rd_data is complete
        // in the same cycle rd_valid rises.
        DRAIN: begin
          if (last_capture) begin
            rd_data  <= acc_next;
            rd_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end

        // rd is deliberately not sampled here; a new request is taken from
        // the following cycle on.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_bytes_reader.sv
// -----------------------------------------------------------------------------
// tb_bridge_bytes_reader
//
// Three copies of bridge_bytes_reader (READ_LATENCY 2, 1 and 7) share one
// request stream, each with its own fixed-latency byte memory. Expected
// memory accesses and returned words are queued when a request is driven and
// checked as the DUTs produce them; busy is compared against a cycle model.
// -----------------------------------------------------------------------------
module tb_bridge_bytes_reader;

  localparam int AW = 25;
  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 1, 7};

  logic        clk;
  logic        reset;
  logic        rd;
  logic [31:0] addr;

  logic [31:0]   rd_data_w     [NI];
  logic          rd_valid_w    [NI];
  logic          busy_w        [NI];
  logic [AW-1:0] mem_addr_w    [NI];
  logic          mem_rd_w      [NI];
  logic [7:0]    mem_rd_data_w [NI];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  // Cycle model per instance.
  int busy_lo  [NI];
  int busy_hi  [NI];
  int done_cyc [NI];

  typedef struct {
    int          inst;
    logic [AW-1:0] a;
    int          cyc;
  } addr_exp_t;

  typedef struct {
    int          inst;
    logic [31:0] w;
    int          cyc;
  } word_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } vec_t;

  addr_exp_t aq[$];
  word_exp_t wq[$];
  vec_t      vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: a few fixed words, a hash of the address elsewhere.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    case (a)
      25'h100: return 8'h12;
      25'h101: return 8'h34;
      25'h102: return 8'h56;
      25'h103: return 8'h78;
      25'h004: return 8'hAA;
      25'h005: return 8'hBB;
      25'h006: return 8'hCC;
      25'h007: return 8'hDD;
      25'h000: return 8'h01;
      25'h001: return 8'h02;
      25'h002: return 8'h03;
      25'h003: return 8'h04;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'b0, a[24]};
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [7:0] pipe [LAT[g]];

    bridge_bytes_reader #(
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(LAT[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .rd         (rd),
      .addr       (addr),
      .rd_data    (rd_data_w[g]),
      .rd_valid   (rd_valid_w[g]),
      .busy       (busy_w[g]),
      .mem_addr   (mem_addr_w[g]),
      .mem_rd     (mem_rd_w[g]),
      .mem_rd_data(mem_rd_data_w[g])
    );

    // Fixed-latency memory; returns a filler byte when not read and is not
    // reset, so late data keeps arriving after a DUT reset.
    always @(posedge clk) begin
      pipe[0] <= mem_rd_w[g] ? mem_byte(mem_addr_w[g]) : 8'hEE;
      for (int i = 1; i < LAT[g]; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rd_data_w[g] = pipe[LAT[g]-1];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int find_addr(input int inst);
    for (int j = 0; j < aq.size(); j++) if (aq[j].inst == inst) return j;
    return -1;
  endfunction

  function automatic int find_word(input int inst);
    for (int j = 0; j < wq.size(); j++) if (wq[j].inst == inst) return j;
    return -1;
  endfunction

  task automatic monitor_inst(input int i);
    int j;
    check($sformatf("busy[%0d]@%0d", i, cyc), 64'(busy_w[i]),
          64'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));
    if (mem_rd_w[i]) begin
      j = find_addr(i);
      if (j < 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mem_rd[%0d]: unexpected access to %0h at cycle %0d, required none",
                 i, mem_addr_w[i], cyc);
      end else begin
        check($sformatf("mem_addr[%0d]", i), 64'(mem_addr_w[i]), 64'(aq[j].a));
        check($sformatf("mem_rd_cycle[%0d]", i), 64'(cyc), 64'(aq[j].cyc));
        aq.delete(j);
      end
    end
    if (rd_valid_w[i]) begin
      j = find_word(i);
      if (j < 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_valid[%0d]: unexpected strobe data %0h at cycle %0d, required none",
                 i, rd_data_w[i], cyc);
      end else begin
        check($sformatf("rd_data[%0d]", i), 64'(rd_data_w[i]), 64'(wq[j].w));
        check($sformatf("rd_valid_cycle[%0d]", i), 64'(cyc), 64'(wq[j].cyc));
        wq.delete(j);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) for (int i = 0; i < NI; i++) monitor_inst(i);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      busy_lo[i]  = 0;
      busy_hi[i]  = -1;
      done_cyc[i] = -100;
    end
    aq.delete();
    wq.delete();
  endtask

  // Drives rd for the current cycle (caller sits just after a negedge) and
  // queues the expected traffic for every instance that is free to accept.
  task automatic drive_rd(input logic [31:0] a, input logic [31:0] w);
    int cr;
    int c0;
    logic [AW-1:0] ea;
    cr   = cyc;
    c0   = cr + 1;
    rd   = 1'b1;
    addr = a;
    for (int i = 0; i < NI; i++) begin
      if (cr > done_cyc[i]) begin
        busy_lo[i]  = c0;
        busy_hi[i]  = c0 + 3 + LAT[i];
        done_cyc[i] = c0 + 4 + LAT[i];
        for (int k = 0; k < 4; k++) begin
          ea = {a[AW-1:2], 2'b00} + AW'(k);
          aq.push_back('{i, ea, c0 + k});
        end
        wq.push_back('{i, w, c0 + 4 + LAT[i]});
      end
    end
    @(negedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((aq.size() != 0 || wq.size() != 0) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_pending", 64'(aq.size() + wq.size()), 64'd0);
    wait_cycles(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_rd_data[%0d]", tag, i), 64'(rd_data_w[i]), 64'd0);
      check($sformatf("%s_rd_valid[%0d]", tag, i), 64'(rd_valid_w[i]), 64'd0);
      check($sformatf("%s_busy[%0d]", tag, i), 64'(busy_w[i]), 64'd0);
      check($sformatf("%s_mem_rd[%0d]", tag, i), 64'(mem_rd_w[i]), 64'd0);
      check($sformatf("%s_mem_addr[%0d]", tag, i), 64'(mem_addr_w[i]), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0102, 32'h1234_5678};
    vecs[1] = '{32'h0000_0004, 32'hAABB_CCDD};
    vecs[2] = '{32'h0000_0003, 32'h0102_0304};
    vecs[3] = '{32'h01FF_FFFC, 32'hFDFC_FFFE};
    vecs[4] = '{32'hFE00_0105, 32'h0504_0706};
    vecs[5] = '{32'h000A_BCDB, 32'h6E6F_6C6D};

    model_reset();
    reset = 1'b1;
    rd    = 1'b0;
    addr  = '0;

    // Reset, then a long idle stretch.
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("after_reset");
    wait_cycles(20);
    check_reset_outputs("idle");

    // Table of single reads, each run to completion on all latencies.
    for (int v = 0; v < 6; v++) begin
      drive_rd(vecs[v].addr, vecs[v].word);
      drain();
      for (int i = 0; i < NI; i++)
        check($sformatf("held_vec%0d[%0d]", v, i), 64'(rd_data_w[i]), 64'(vecs[v].word));
    end

    // Busy collision: second request in cycle 3 is dropped everywhere.
    drive_rd(32'h0000_0000, 32'h0102_0304);
    wait_cycles(2);
    drive_rd(32'h0000_0010, 32'h1011_1213);
    drain();

    // Request in the DONE cycle of latency 2: only latency 1 is idle by then.
    drive_rd(32'h0000_0000, 32'h0102_0304);
    wait_cycles(6);
    drive_rd(32'h0000_0010, 32'h1011_1213);
    drain();

    // Back-to-back: second request in the cycle after the latency-2 rd_valid.
    drive_rd(32'h0000_0100, 32'h1234_5678);
    wait_cycles(7);
    drive_rd(32'h0000_0004, 32'hAABB_CCDD);
    wait_cycles(2);
    check("hold_between_reads[0]", 64'(rd_data_w[0]), 64'h1234_5678);
    drain();

    // Reset in cycle 3 of a read: immediate abort, then a clean read.
    drive_rd(32'h0000_0100, 32'h1234_5678);
    wait_cycles(2);
    #1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("abort_mem_rd[%0d]", i), 64'(mem_rd_w[i]), 64'd0);
      check($sformatf("abort_busy[%0d]", i), 64'(busy_w[i]), 64'd0);
      check($sformatf("abort_rd_valid[%0d]", i), 64'(rd_valid_w[i]), 64'd0);
    end
    model_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(10);
    drive_rd(32'h0000_0100, 32'h1234_5678);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
